// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer between the fetch PC and the AXI imem read channels
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,

  output logic [ADDR_W-1:0] axi_imem_araddr,
  output logic              axi_imem_arvalid,
  input  logic              axi_imem_arready,
  input  logic [31:0]       axi_imem_rdata,
  input  logic [1:0]        axi_imem_rresp,
  input  logic              axi_imem_rvalid,
  output logic              axi_imem_rready,

  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,

  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AR      = 3'd1,
    S_R       = 3'd2,
    S_HOLD    = 3'd3,
    S_DISCARD = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              instr_valid_q;
  logic              fault_q;
  logic              pend_q;

  logic [ADDR_W-1:0] redir_pc_d;
  logic [ADDR_W-1:0] pc_inc_d;
  logic [ADDR_W-1:0] pc_d;
  logic              accept_d;
  logic              resp_ok_d;

  // The two low target bits are dropped on purpose: fetches are word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign redir_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign pc_inc_d   = pc_q + ADDR_W'(4);
  assign accept_d   = (state_q == S_HOLD) && instr_ready_i;
  assign resp_ok_d  = (axi_imem_rresp == 2'b00);

  // Next fetch PC: a redirect always wins over the sequential advance on accept.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redir_pc_d;
    end else if (accept_d) begin
      pc_d = pc_inc_d;
    end
  end

  // Fetch FSM with all outputs registered; araddr is captured on AR entry so a
  // redirect during an unfinished handshake cannot disturb the address on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE: begin
          state_q   <= S_AR;
          arvalid_q <= 1'b1;
          araddr_q  <= pc_d;
        end

        S_AR: begin
          if (redirect_i) begin
            pend_q <= 1'b1;
          end
          if (axi_imem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (pend_q || redirect_i) ? S_DISCARD : S_R;
          end
        end

        S_R: begin
          if (axi_imem_rvalid) begin
            rready_q <= 1'b0;
            if (redirect_i) begin
              // Beat arrives together with the redirect: drop it and refetch.
              state_q   <= S_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= pc_d;
            end else if (resp_ok_d) begin
              instr_q       <= axi_imem_rdata;
              pc_out_q      <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end else if (redirect_i) begin
            pend_q  <= 1'b1;
            state_q <= S_DISCARD;
          end
        end

        S_HOLD: begin
          if (redirect_i || instr_ready_i) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_AR;
            arvalid_q     <= 1'b1;
            araddr_q      <= pc_d;
          end
        end

        S_DISCARD: begin
          if (axi_imem_rvalid) begin
            rready_q  <= 1'b0;
            pend_q    <= 1'b0;
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= pc_d;
          end
        end

        S_FAULT: begin
          if (redirect_i) begin
            fault_q   <= 1'b0;
            state_q   <= S_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= pc_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign axi_imem_araddr  = araddr_q;
  assign axi_imem_arvalid = arvalid_q;
  assign axi_imem_rready  = rready_q;
  assign instr_o          = instr_q;
  assign pc_o             = pc_out_q;
  assign instr_valid_o    = instr_valid_q;
  assign fault_o          = fault_q;

endmodule
